// File: rtl/sr_fifo_arbiter_pkg.sv
// Shared defaults and helpers for the sr_fifo requester arbiter.
package sr_fifo_arbiter_pkg;

    localparam int unsigned DEF_NREQ       = 2;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 8;

    // Round-robin index: (base + off) wrapped into 0..n-1.
    function automatic int unsigned rrWrap(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/sr_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the priority
// pointer (wrapping), and moves the pointer past the winner when en accepts it.
module sr_rr_arbiter
    import sr_fifo_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    // Search from ptr upward, first active request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'(rrWrap(32'(ptr), k, N));
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Priority pointer advances only on an accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && any) begin
            ptr <= IDX_W'(rrWrap(32'(gnt_idx), 1, N));
        end
    end

endmodule

// File: rtl/sr_fifo_arbiter.sv
// Shares one single-push/single-pop sr_fifo between NREQ requesters with
// independent round-robin push and pop grants and a registered pop response.
module sr_fifo_arbiter
    import sr_fifo_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = DEF_NREQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            push_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] push_data,
    output logic [NREQ-1:0]            push_ready,
    input  logic [NREQ-1:0]            pop_valid,
    output logic [NREQ-1:0]            pop_ready,
    output logic                       rsp_valid,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       fifo_push,
    output logic [DATA_WIDTH-1:0]      fifo_wdata,
    output logic                       fifo_pop,
    input  logic [DATA_WIDTH-1:0]      fifo_rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [NREQ-1:0]  pushGnt;
    logic [ID_W-1:0]  pushIdx;
    logic             pushAny;
    logic [NREQ-1:0]  popGnt;
    logic [ID_W-1:0]  popIdx;
    logic             popAny;
    logic [CNT_W-1:0] countNext;

    sr_rr_arbiter #(.N(NREQ)) uPushArb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (push_valid),
        .en      (~full),
        .gnt     (pushGnt),
        .gnt_idx (pushIdx),
        .any     (pushAny)
    );

    sr_rr_arbiter #(.N(NREQ)) uPopArb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (pop_valid),
        .en      (~empty),
        .gnt     (popGnt),
        .gnt_idx (popIdx),
        .any     (popAny)
    );

    // Handshakes gate only on registered occupancy; no full/empty bypass.
    always_comb begin
        push_ready = pushGnt & {NREQ{~full}};
        pop_ready  = popGnt & {NREQ{~empty}};
        fifo_push  = |push_ready;
        fifo_pop   = |pop_ready;
    end

    // Write-data mux for the granted push slot.
    always_comb begin
        fifo_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pushAny && pushIdx == ID_W'(i)) begin
                fifo_wdata = push_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Occupancy after this cycle's handshakes.
    always_comb begin
        countNext = count;
        unique case ({fifo_push, fifo_pop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    // Occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= countNext;
            full  <= (countNext == CNT_W'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    // Pop response channel: one cycle after the handshake, id/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (fifo_pop) begin
            rsp_valid <= 1'b1;
            rsp_id    <= popIdx;
            rsp_data  <= fifo_rdata;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sr_fifo_arbiter.sv
// Directed bench for sr_fifo_arbiter with NREQ=2, DEPTH=8 and a behavioural sr_fifo.
module tb_sr_fifo_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  push_valid;
    logic [NREQ*DW-1:0] push_data;
    logic [NREQ-1:0]  push_ready;
    logic [NREQ-1:0]  pop_valid;
    logic [NREQ-1:0]  pop_ready;
    logic             rsp_valid;
    logic [0:0]       rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             fifo_push;
    logic [DW-1:0]    fifo_wdata;
    logic             fifo_pop;
    logic [DW-1:0]    fifo_rdata;
    logic [3:0]       count;
    logic             full;
    logic             empty;

    int checks   = 0;
    int failures = 0;

    sr_fifo_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .fifo_push  (fifo_push),
        .fifo_wdata (fifo_wdata),
        .fifo_pop   (fifo_pop),
        .fifo_rdata (fifo_rdata),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Behavioural sr_fifo: head word is presented combinationally after each edge.
    logic [DW-1:0] fifoQ[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifoQ.delete();
            fifo_rdata <= '0;
        end else begin
            if (fifo_pop && fifoQ.size() > 0) void'(fifoQ.pop_front());
            if (fifo_push) fifoQ.push_back(fifo_wdata);
            fifo_rdata <= (fifoQ.size() > 0) ? fifoQ[0] : '0;
        end
    end

    task automatic drive(input logic [1:0] pv, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d0, input logic [1:0] qv);
        @(negedge clk);
        push_valid = pv;
        push_data  = {d1, d0};
        pop_valid  = qv;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push_valid = '0; push_data = '0; pop_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        drive(2'b00, 0, 0, 2'b00);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({push_ready, pop_ready, fifo_push, fifo_pop} !== 6'b0) begin failures++;
            $display("FAIL reset_ready got=%b_%b exp=00_00", push_ready, pop_ready); end
    endtask

    task automatic test_fill();
        int a = 0, b = 0;
        logic [1:0] expGnt;
        logic [DW-1:0] expW;
        for (int n = 0; n < 8; n++) begin
            drive(2'b11, 32'hB0 + DW'(b), 32'hA0 + DW'(a), 2'b00);
            expGnt = (n % 2 == 0) ? 2'b01 : 2'b10;
            expW   = (n % 2 == 0) ? 32'hA0 + DW'(a) : 32'hB0 + DW'(b);
            checks++; if (push_ready !== expGnt) begin failures++;
                $display("FAIL fill_grant n=%0d got=%b exp=%b", n, push_ready, expGnt); end
            checks++; if (fifo_wdata !== expW) begin failures++;
                $display("FAIL fill_wdata n=%0d got=%h exp=%h", n, fifo_wdata, expW); end
            if (n % 2 == 0) a++; else b++;
        end
        drive(2'b11, 32'hB4, 32'hA4, 2'b00);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++;
            $display("FAIL fill_full got full=%b count=%0d exp full=1 count=8", full, count); end
        checks++; if (push_ready !== 2'b00 || fifo_push !== 1'b0) begin failures++;
            $display("FAIL fill_blocked got=%b exp=00", push_ready); end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] expD [8];
        expD = '{32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hB3, 32'hC0};
        drive(2'b01, 0, 32'hC0, 2'b01);
        checks++; if (push_ready !== 2'b00 || pop_ready !== 2'b01) begin failures++;
            $display("FAIL full_pp_ready got push=%b pop=%b exp push=00 pop=01", push_ready, pop_ready); end
        @(posedge clk); #1;
        checks++; if (count !== 4'd7) begin failures++; $display("FAIL full_pp_count got=%0d exp=7", count); end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hA0 || rsp_id !== 1'b0) begin failures++;
            $display("FAIL full_pp_rsp got v=%b id=%0d d=%h exp v=1 id=0 d=a0", rsp_valid, rsp_id, rsp_data); end
        drive(2'b01, 0, 32'hC0, 2'b00);
        checks++; if (push_ready !== 2'b01) begin failures++; $display("FAIL full_pp_push got=%b exp=01", push_ready); end
        @(posedge clk); #1;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++;
            $display("FAIL full_pp_refill got count=%0d full=%b exp 8/1", count, full); end
        for (int k = 0; k < 8; k++) begin
            drive(2'b00, 0, 0, 2'b11);
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== expD[k] || rsp_id !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL drain_rsp k=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                         k, rsp_valid, rsp_id, rsp_data, (k % 2 == 0) ? 1 : 0, expD[k]);
            end
        end
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin failures++;
            $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_empty_no_bypass();
        drive(2'b01, 0, 32'h55, 2'b10);
        checks++; if (pop_ready !== 2'b00 || push_ready !== 2'b01) begin failures++;
            $display("FAIL bypass_ready got pop=%b push=%b exp pop=00 push=01", pop_ready, push_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || count !== 4'd1) begin failures++;
            $display("FAIL bypass_first got v=%b count=%0d exp v=0 count=1", rsp_valid, count); end
        drive(2'b00, 0, 0, 2'b10);
        checks++; if (pop_ready !== 2'b10) begin failures++; $display("FAIL bypass_pop got=%b exp=10", pop_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || rsp_id !== 1'b1) begin failures++;
            $display("FAIL bypass_rsp got v=%b id=%0d d=%h exp v=1 id=1 d=55", rsp_valid, rsp_id, rsp_data); end
    endtask

    task automatic test_steady();
        logic [DW-1:0] expW;
        for (int n = 0; n < 3; n++) begin
            drive(2'b10, 32'h200 + DW'(n), 0, 2'b00);
        end
        for (int n = 0; n < 20; n++) begin
            drive(2'b10, 32'h100 + DW'(n), 0, 2'b01);
            checks++; if (push_ready !== 2'b10 || pop_ready !== 2'b01) begin failures++;
                $display("FAIL steady_ready n=%0d got push=%b pop=%b exp 10/01", n, push_ready, pop_ready); end
            @(posedge clk); #1;
            expW = (n < 3) ? 32'h200 + DW'(n) : 32'h100 + DW'(n - 3);
            checks++; if (count !== 4'd3 || rsp_valid !== 1'b1 || rsp_data !== expW) begin failures++;
                $display("FAIL steady_rsp n=%0d got count=%0d v=%b d=%h exp count=3 v=1 d=%h",
                         n, count, rsp_valid, rsp_data, expW); end
        end
    endtask

    task automatic test_async_reset();
        // Leave both pointers at 1 before reset.
        drive(2'b01, 0, 32'h300, 2'b01);
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got v=%b exp=1", rsp_valid); end
        #2 rst_n = 1'b0; push_valid = '0; pop_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++;
            $display("FAIL areset_state got v=%b count=%0d empty=%b full=%b exp 0/0/1/0", rsp_valid, count, empty, full); end
        @(negedge clk); rst_n = 1'b1;
        drive(2'b11, 32'h401, 32'h400, 2'b00);
        checks++; if (push_ready !== 2'b01) begin failures++; $display("FAIL areset_push_ptr got=%b exp=01", push_ready); end
        drive(2'b00, 0, 0, 2'b11);
        checks++; if (pop_ready !== 2'b01) begin failures++; $display("FAIL areset_pop_ptr got=%b exp=01", pop_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h400) begin failures++;
            $display("FAIL areset_rsp got v=%b d=%h exp v=1 d=400", rsp_valid, rsp_data); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_empty_no_bypass();
        test_steady();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
